// File: rtl/counter_capture_fifo.sv
// counter_capture_fifo
//   Samples the upstream enable counter's `result` bus on a capture request,
//   tags each sample with a wrap-around flag, and stores it in a small
//   first-word-fall-through FIFO. A host or logging stage drains the FIFO over
//   a valid/ready handshake.
//
//   Optional feature (macro CAP_EDGE_TRIG_EN):
//     defined   - one capture per rising edge of trig (trig & ~trig_q)
//     undefined - level-sensitive capture, every cycle trig is high
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   result     counter value from the upstream counter
//   trig       capture request
//   clr_ovf    clears the sticky overflow flag
//   out_data   head entry: bit WIDTH = wrap tag, bits WIDTH-1:0 = sample
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head entry
//   count      current occupancy
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky, set when a capture is dropped
module counter_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         result,
  input  logic                     trig,
  input  logic                     clr_ovf,
  output logic [WIDTH:0]           out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] prev_result;
  logic             wrap_pend;

  logic             cap_req;
  logic             wrap_evt;
  logic             pop;
  logic             push;
  logic             drop;

`ifdef CAP_EDGE_TRIG_EN
  logic trig_q;

  always_ff @(posedge clk) begin
    if (reset) trig_q <= 1'b0;
    else       trig_q <= trig;
  end

  assign cap_req = trig & ~trig_q;
`else
  assign cap_req = trig;
`endif

  // A wrap is only the max-to-zero transition; a counter reset from any
  // other value to zero is not tagged.
  assign wrap_evt  = (prev_result == {WIDTH{1'b1}}) && (result == '0);

  assign empty     = (cnt == '0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign out_valid = ~empty;
  assign count     = cnt;
  assign out_data  = mem[rd_ptr];

  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push = cap_req & (~full | pop);
  assign drop = cap_req & full & ~pop;

  // Control: pointers, occupancy, wrap tracking, sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      prev_result <= '0;
      wrap_pend   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev_result <= result;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      // A dropped capture leaves the pending wrap in place so that the next
      // successful push still carries the tag.
      if (push)          wrap_pend <= 1'b0;
      else if (wrap_evt) wrap_pend <= 1'b1;

      // Set has priority over clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Data: storage is not reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wrap_pend | wrap_evt, result};
  end

endmodule

// File: tb/tb_counter_capture_fifo.sv
module tb_counter_capture_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  result;
  logic        trig;
  logic        clr_ovf;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  counter_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .result    (result),
    .trig      (trig),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One capture: trig pulsed for a single cycle, then one idle cycle.
  task automatic cap(input logic [7:0] v);
    result = v;
    trig   = 1'b1;
    tick();
    trig   = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; result = 8'h00; trig = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_empty",    32'(empty),     32'd1);
    chk("rst_full",     32'(full),      32'd0);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);

    // Single capture, one-cycle latency, no bypass
    result = 8'h05; trig = 1'b1;
    tick();
    chk("t1_nobypass_prev", 32'(count), 32'd1);
    trig = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'h005);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_drain_empty", 32'(empty), 32'd1);

    // Same-cycle check that a push request does not show valid yet
    result = 8'h06; trig = 1'b1;
    #1;
    chk("t1_no_bypass", 32'(out_valid), 32'd0);
    tick();
    trig = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Wrap tag: FE -> FF -> 00 -> 01, capture at 01
    result = 8'hFE; tick();
    result = 8'hFF; tick();
    result = 8'h00; tick();
    result = 8'h01; trig = 1'b1; tick();
    trig = 1'b0;
    chk("t2_wrap_tag", 32'(out_data), 32'h101);
    result = 8'h02; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    result = 8'h03; trig = 1'b1; tick();
    trig = 1'b0;
    chk("t2_no_tag", 32'(out_data), 32'h003);
    chk("t2_count",  32'(count),    32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifndef CAP_EDGE_TRIG_EN
    // Level-mode overflow: trig held six cycles
    trig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      result = 8'h10 + 8'(i);
      tick();
    end
    trig = 1'b0;
    chk("t3_count",    32'(count),    32'd4);
    chk("t3_full",     32'(full),     32'd1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d", i), 32'(out_data), 32'h010 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty",     32'(empty),    32'd1);
    chk("t3_ovf_kept",  32'(overflow), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("t3_ovf_clr",   32'(overflow), 32'd0);
`else
    // Edge mode: trig held five cycles yields one capture
    trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      result = 8'h60 + 8'(i);
      tick();
    end
    trig = 1'b0;
    chk("t6_count",    32'(count),    32'd1);
    chk("t6_data",     32'(out_data), 32'h060);
    chk("t6_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t6_empty",    32'(empty),    32'd1);
`endif

    // Full FIFO with simultaneous push and pop
    cap(8'h30); cap(8'h31); cap(8'h32); cap(8'h33);
    chk("t4_full", 32'(full), 32'd1);
    result = 8'h40; trig = 1'b1; out_ready = 1'b1;
    tick();
    trig = 1'b0; out_ready = 1'b0;
    chk("t4_count",    32'(count),    32'd4);
    chk("t4_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    chk("t4_d0", 32'(out_data), 32'h031); tick();
    chk("t4_d1", 32'(out_data), 32'h032); tick();
    chk("t4_d2", 32'(out_data), 32'h033); tick();
    chk("t4_d3", 32'(out_data), 32'h040); tick();
    out_ready = 1'b0;
    chk("t4_empty", 32'(empty), 32'd1);

    // Dropped capture during a wrap, with clr_ovf in the same cycle
    cap(8'h50); cap(8'h51); cap(8'h52); cap(8'h53);
    result = 8'hFF; tick();
    result = 8'h00; trig = 1'b1; clr_ovf = 1'b1; tick();
    trig = 1'b0; clr_ovf = 1'b0;
    chk("t4b_set_wins", 32'(overflow), 32'd1);
    chk("t4b_count",    32'(count),    32'd4);
    result = 8'h07; out_ready = 1'b1; tick(); out_ready = 1'b0;
    cap(8'h08);
    out_ready = 1'b1;
    chk("t4b_d0", 32'(out_data), 32'h051); tick();
    chk("t4b_d1", 32'(out_data), 32'h052); tick();
    chk("t4b_d2", 32'(out_data), 32'h053); tick();
    chk("t4b_d3_tag", 32'(out_data), 32'h108); tick();
    out_ready = 1'b0;
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;

    // Reset mid-operation with a pending wrap and a set overflow
    cap(8'h20); cap(8'h21); cap(8'h22); cap(8'h23);
    result = 8'h24; trig = 1'b1; tick(); trig = 1'b0; tick();
    chk("t5_pre_ovf", 32'(overflow), 32'd1);
    result = 8'hFF; tick();
    result = 8'h00; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_count",    32'(count),     32'd0);
    chk("t5_valid",    32'(out_valid), 32'd0);
    chk("t5_overflow", 32'(overflow),  32'd0);
    cap(8'h09);
    chk("t5_no_tag", 32'(out_data), 32'h009);
    chk("t5_count1", 32'(count),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
